// File: rtl/clock_display.sv
// Four-digit multiplexed 7-segment clock display driver.
// Scans min0, min1, hour0, hour1 in turn with PWM dimming inside each slot,
// a blinking colon on the hour0 slot, leading-zero blanking of hour1 and a
// per-frame snapshot of the digit inputs so a frame is never torn.
// All outputs are registered and active-low.
module clock_display #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] hour1,
    input  logic [3:0] hour0,
    input  logic [2:0] min1,
    input  logic [3:0] min0,
    input  logic       blank_lz,
    input  logic       colon_en,
    input  logic [1:0] dim,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int SC_W = $clog2(SCAN_DIV);
    localparam int BC_W = $clog2(BLINK_DIV);
    localparam int QUARTER = SCAN_DIV / 4;
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(SCAN_DIV - 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(BLINK_DIV - 1);

    logic [SC_W-1:0] sc_q, sc_d;
    logic [1:0]      di_q, di_d;
    logic [BC_W-1:0] bc_q, bc_d;
    logic            ph_q, ph_d;
    logic            first_q, first_d;
    logic [1:0]      sh_h1_q, sh_h1_d;
    logic [3:0]      sh_h0_q, sh_h0_d;
    logic [2:0]      sh_m1_q, sh_m1_d;
    logic [3:0]      sh_m0_q, sh_m0_d;
    logic [3:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;

    logic            sc_wrap, bc_wrap, load, active, blank, dash;
    logic [1:0]      v_h1;
    logic [3:0]      v_h0, v_m0, val;
    logic [2:0]      v_m1;
    logic [31:0]     win;

    // Active-low 7-segment patterns {g,f,e,d,c,b,a}; anything else is a dash.
    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'd0:    seg_of = 7'b1000000;
            4'd1:    seg_of = 7'b1111001;
            4'd2:    seg_of = 7'b0100100;
            4'd3:    seg_of = 7'b0110000;
            4'd4:    seg_of = 7'b0011001;
            4'd5:    seg_of = 7'b0010010;
            4'd6:    seg_of = 7'b0000010;
            4'd7:    seg_of = 7'b1111000;
            4'd8:    seg_of = 7'b0000000;
            4'd9:    seg_of = 7'b0010000;
            default: seg_of = 7'b0111111;
        endcase
    endfunction

    // Next-state logic for the scan/blink counters, snapshot and output pins.
    always_comb begin
        sc_wrap = (sc_q == SC_LAST);
        sc_d    = sc_wrap ? '0 : sc_q + 1'b1;
        di_d    = sc_wrap ? di_q + 2'd1 : di_q;

        bc_wrap = (bc_q == BC_LAST);
        bc_d    = bc_wrap ? '0 : bc_q + 1'b1;
        ph_d    = ph_q ^ bc_wrap;

        first_d = 1'b0;

        // Snapshot on the first clock out of reset and as the frame wraps 3->0.
        load    = first_q | (sc_wrap && (di_q == 2'd3));
        sh_h1_d = load ? hour1 : sh_h1_q;
        sh_h0_d = load ? hour0 : sh_h0_q;
        sh_m1_d = load ? min1  : sh_m1_q;
        sh_m0_d = load ? min0  : sh_m0_q;

        // The first slot after reset is drawn from the snapshot being taken
        // on that same clock, so no stale zero is flashed.
        v_h1 = first_q ? sh_h1_d : sh_h1_q;
        v_h0 = first_q ? sh_h0_d : sh_h0_q;
        v_m1 = first_q ? sh_m1_d : sh_m1_q;
        v_m0 = first_q ? sh_m0_d : sh_m0_q;

        val  = 4'd0;
        dash = 1'b0;
        case (di_q)
            2'd0: begin val = v_m0;          dash = (v_m0 > 4'd9); end
            2'd1: begin val = {1'b0, v_m1};  dash = (v_m1 > 3'd5); end
            2'd2: begin val = v_h0;          dash = (v_h0 > 4'd9); end
            default: begin val = {2'b00, v_h1}; dash = (v_h1 == 2'd3); end
        endcase

        win    = (32'(dim) + 32'd1) * 32'(QUARTER);
        active = (32'(sc_q) < win);
        blank  = (di_q == 2'd3) && blank_lz && (v_h1 == 2'd0);

        an_d = 4'hF;
        if (active && !blank) begin
            an_d = ~(4'b0001 << di_q);
        end
        seg_d = blank ? 7'h7F : (dash ? 7'b0111111 : seg_of(val));
        dp_d  = !((di_q == 2'd2) && colon_en && ph_q && active);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sc_q    <= '0;
            di_q    <= 2'd0;
            bc_q    <= '0;
            ph_q    <= 1'b0;
            first_q <= 1'b1;
            sh_h1_q <= 2'd0;
            sh_h0_q <= 4'd0;
            sh_m1_q <= 3'd0;
            sh_m0_q <= 4'd0;
            an_q    <= 4'hF;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
        end else begin
            sc_q    <= sc_d;
            di_q    <= di_d;
            bc_q    <= bc_d;
            ph_q    <= ph_d;
            first_q <= first_d;
            sh_h1_q <= sh_h1_d;
            sh_h0_q <= sh_h0_d;
            sh_m1_q <= sh_m1_d;
            sh_m0_q <= sh_m0_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_clock_display.sv
// Directed bench for clock_display with SCAN_DIV=8 and BLINK_DIV=20.
// Inputs change just after a falling edge; outputs are sampled on falling edges.
// Sample idx after a reset release is taken after the (idx+1)-th rising edge,
// so it shows sc = idx%8, di = (idx/8)%4, blink phase = (idx/20)%2.
module tb_clock_display;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] hour1 = 2'd0;
    logic [3:0] hour0 = 4'd0;
    logic [2:0] min1 = 3'd0;
    logic [3:0] min0 = 4'd0;
    logic       blank_lz = 1'b0;
    logic       colon_en = 1'b0;
    logic [1:0] dim = 2'd3;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    clock_display #(.SCAN_DIV(8), .BLINK_DIV(20)) dut (
        .clk(clk), .rst(rst), .hour1(hour1), .hour0(hour0), .min1(min1),
        .min0(min0), .blank_lz(blank_lz), .colon_en(colon_en), .dim(dim),
        .an(an), .seg(seg), .dp(dp)
    );

    function automatic logic [6:0] exp_seg(input int v);
        case (v)
            0: exp_seg = 7'h40;  1: exp_seg = 7'h79;  2: exp_seg = 7'h24;
            3: exp_seg = 7'h30;  4: exp_seg = 7'h19;  5: exp_seg = 7'h12;
            6: exp_seg = 7'h02;  7: exp_seg = 7'h78;  8: exp_seg = 7'h00;
            9: exp_seg = 7'h10;  default: exp_seg = 7'h3F;
        endcase
    endfunction

    function automatic logic [3:0] an_of(input int slot);
        case (slot)
            0: an_of = 4'b1110;  1: an_of = 4'b1101;
            2: an_of = 4'b1011;  default: an_of = 4'b0111;
        endcase
    endfunction

    task automatic set_digits(input int h1, input int h0, input int m1, input int m0);
        hour1 = 2'(h1); hour0 = 4'(h0); min1 = 3'(m1); min0 = 4'(m0);
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_reset();
        set_digits(1, 2, 3, 4);
        dim = 2'd3; blank_lz = 1'b0; colon_en = 1'b1;
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++; if (an !== 4'hF) begin n_fail++; $display("FAIL reset_an got %b want 1111", an); end
            n_checks++; if (seg !== 7'h7F) begin n_fail++; $display("FAIL reset_seg got %h want 7f", seg); end
            n_checks++; if (dp !== 1'b1) begin n_fail++; $display("FAIL reset_dp got %b want 1", dp); end
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (an !== 4'b1110) begin n_fail++; $display("FAIL reset_first_an got %b want 1110", an); end
        n_checks++; if (seg !== exp_seg(4)) begin n_fail++; $display("FAIL reset_first_seg got %h want %h", seg, exp_seg(4)); end
        colon_en = 1'b0;
    endtask

    task automatic test_basic_scan();
        int dig [4] = '{4, 3, 2, 1};
        set_digits(1, 2, 3, 4);
        dim = 2'd3; blank_lz = 1'b0; colon_en = 1'b0;
        do_reset();
        for (int idx = 0; idx < 40; idx++) begin
            int slot;
            @(negedge clk);
            slot = (idx / 8) % 4;
            n_checks++; if (an !== an_of(slot)) begin n_fail++; $display("FAIL scan_an idx=%0d got %b want %b", idx, an, an_of(slot)); end
            n_checks++; if (seg !== exp_seg(dig[slot])) begin n_fail++; $display("FAIL scan_seg idx=%0d got %h want %h", idx, seg, exp_seg(dig[slot])); end
            n_checks++; if (dp !== 1'b1) begin n_fail++; $display("FAIL scan_dp idx=%0d got %b want 1", idx, dp); end
        end
    endtask

    task automatic test_snapshot();
        set_digits(1, 2, 3, 4);
        dim = 2'd3; blank_lz = 1'b0; colon_en = 1'b0;
        do_reset();
        for (int idx = 0; idx < 64; idx++) begin
            int slot, frame, v;
            @(negedge clk);
            slot = (idx / 8) % 4;
            frame = idx / 32;
            case (slot)
                0: v = (frame == 0) ? 4 : 7;
                1: v = 3;
                2: v = 2;
                default: v = (frame == 0) ? 1 : 2;
            endcase
            n_checks++; if (an !== an_of(slot)) begin n_fail++; $display("FAIL snap_an idx=%0d got %b want %b", idx, an, an_of(slot)); end
            n_checks++; if (seg !== exp_seg(v)) begin n_fail++; $display("FAIL snap_seg idx=%0d got %h want %h", idx, seg, exp_seg(v)); end
            if (idx == 10) begin
                min0 = 4'd7;
                hour1 = 2'd2;
            end
        end
    endtask

    task automatic test_dash_blank();
        set_digits(0, 12, 6, 5);
        dim = 2'd3; blank_lz = 1'b1; colon_en = 1'b0;
        do_reset();
        for (int idx = 0; idx < 96; idx++) begin
            int slot, frame;
            logic [3:0] ea;
            logic [6:0] es;
            @(negedge clk);
            slot = (idx / 8) % 4;
            frame = idx / 32;
            ea = an_of(slot);
            case (slot)
                0: es = 7'h12;
                1: es = 7'h3F;
                2: es = 7'h3F;
                default: begin
                    if (frame == 0) begin ea = 4'hF; es = 7'h7F; end
                    else if (frame == 1) es = 7'h40;
                    else es = 7'h3F;
                end
            endcase
            n_checks++; if (an !== ea) begin n_fail++; $display("FAIL dash_an idx=%0d got %b want %b", idx, an, ea); end
            n_checks++; if (seg !== es) begin n_fail++; $display("FAIL dash_seg idx=%0d got %h want %h", idx, seg, es); end
            if (idx == 31) blank_lz = 1'b0;
            if (idx == 40) hour1 = 2'd3;
        end
    endtask

    task automatic test_dim();
        int cnt;
        set_digits(1, 2, 3, 4);
        dim = 2'd0; blank_lz = 1'b0; colon_en = 1'b0;
        do_reset();
        cnt = 0;
        for (int idx = 0; idx < 64; idx++) begin
            int slot, sc, want;
            logic [3:0] ea;
            @(negedge clk);
            slot = (idx / 8) % 4;
            sc = idx % 8;
            ea = (sc < (int'(dim) + 1) * 2) ? an_of(slot) : 4'hF;
            n_checks++; if (an !== ea) begin n_fail++; $display("FAIL dim_an idx=%0d got %b want %b", idx, an, ea); end
            if (an != 4'hF) cnt++;
            if (sc == 7) begin
                want = (idx < 32) ? 2 : (idx < 48) ? 4 : 8;
                n_checks++; if (cnt != want) begin n_fail++; $display("FAIL dim_count idx=%0d got %0d want %0d", idx, cnt, want); end
                cnt = 0;
            end
            if (idx == 31) dim = 2'd1;
            if (idx == 49) dim = 2'd3;
        end
    endtask

    task automatic test_colon();
        set_digits(1, 2, 3, 4);
        dim = 2'd3; blank_lz = 1'b0; colon_en = 1'b1;
        do_reset();
        for (int idx = 0; idx < 200; idx++) begin
            int di, ph;
            logic edp;
            @(negedge clk);
            di = (idx / 8) % 4;
            ph = (idx / 20) % 2;
            edp = !(di == 2 && ph == 1 && colon_en);
            n_checks++; if (dp !== edp) begin n_fail++; $display("FAIL colon_dp idx=%0d got %b want %b", idx, dp, edp); end
            if (idx == 113) colon_en = 1'b0;
            if (idx == 115) colon_en = 1'b1;
            if (idx == 159) colon_en = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        set_digits(1, 2, 3, 4);
        dim = 2'd3; blank_lz = 1'b0; colon_en = 1'b1;
        do_reset();
        for (int idx = 0; idx < 19; idx++) @(negedge clk);
        n_checks++; if (an !== 4'b1011) begin n_fail++; $display("FAIL mid_pre_an got %b want 1011", an); end
        rst = 1'b1;
        min0 = 4'd9;
        @(negedge clk);
        n_checks++; if (an !== 4'hF) begin n_fail++; $display("FAIL mid_rst_an got %b want 1111", an); end
        n_checks++; if (seg !== 7'h7F) begin n_fail++; $display("FAIL mid_rst_seg got %h want 7f", seg); end
        n_checks++; if (dp !== 1'b1) begin n_fail++; $display("FAIL mid_rst_dp got %b want 1", dp); end
        rst = 1'b0;
        for (int idx = 0; idx < 9; idx++) begin
            @(negedge clk);
            if (idx < 8) begin
                n_checks++; if (an !== 4'b1110) begin n_fail++; $display("FAIL mid_rel_an idx=%0d got %b want 1110", idx, an); end
                n_checks++; if (seg !== exp_seg(9)) begin n_fail++; $display("FAIL mid_rel_seg idx=%0d got %h want %h", idx, seg, exp_seg(9)); end
            end else begin
                n_checks++; if (an !== 4'b1101) begin n_fail++; $display("FAIL mid_rel_next_an got %b want 1101", an); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_snapshot();
        test_dash_blank();
        test_dim();
        test_colon();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_display.md
CLOCK_DISPLAY -- requirements
Module: clock_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000: clocks per digit slot (1 kHz per digit at 50 MHz); legal range 4 or more, multiple of 4.
REQ-002 SHALL have parameter BLINK_DIV, default 25000000: clocks per colon half-period (0.5 s at 50 MHz); legal range 2 or more.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port hour1, input, 2 bits: BCD tens of hours, from the time-keeping counter.
REQ-006 SHALL have port hour0, input, 4 bits: BCD units of hours.
REQ-007 SHALL have port min1, input, 3 bits: BCD tens of minutes.
REQ-008 SHALL have port min0, input, 4 bits: BCD units of minutes.
REQ-009 SHALL have port blank_lz, input, 1 bit: when 1, blank the hour1 digit if its value is 0.
REQ-010 SHALL have port colon_en, input, 1 bit: when 1, enable the blinking colon.
REQ-011 SHALL have port dim, input, 2 bits: brightness level, 0 is dimmest and 3 is full.
REQ-012 SHALL have port an, output, 4 bits: digit anodes, active-low; an[0] is min0 and an[3] is hour1.
REQ-013 SHALL have port seg, output, 7 bits: segments {g,f,e,d,c,b,a}, active-low.
REQ-014 SHALL have port dp, output, 1 bit: colon/decimal point, active-low.

Function
REQ-015 SHALL keep a slot counter sc that counts 0..SCAN_DIV-1 and wraps to 0.
REQ-016 SHALL advance a 2-bit digit index di when sc==SCAN_DIV-1, with order 0,1,2,3,0 and wrap 3 to 0.
REQ-017 SHALL map di to digits as follows: 0 is min0, 1 is min1, 2 is hour0, 3 is hour1.
REQ-018 SHALL load the shadow registers from all four digit inputs at the first clock after reset release, and on every clock where di wraps 3 to 0.
REQ-019 SHALL drive displayed values only from the shadow registers, so input changes mid-frame never tear a frame.
REQ-020 SHALL decode values 0-9 to standard 7-segment patterns; for example, 0 is seg=7'b1000000 and 8 is seg=7'b0000000.
REQ-021 SHALL show a dash (segment g only, seg=7'b0111111) for any out-of-range digit value: min0 or hour0 greater than 9, min1 greater than 5, hour1 equal to 3.
REQ-022 SHALL not perform range checking across digits; for example, hour 29 is displayed as given.
REQ-023 SHALL drive the active anode low only while sc < (dim+1)*(SCAN_DIV/4); outside that window all anodes are high.
REQ-024 SHALL blank the digit entirely when di==3, blank_lz==1 and shadow hour1==0: anode high, seg=7'h7F.
REQ-025 SHALL keep a blink counter 0..BLINK_DIV-1 and toggle a blink phase bit at the terminal count.
REQ-026 SHALL drive dp low only when di==2, colon_en==1, blink phase==1, and the anode is active; otherwise dp is high.
REQ-027 SHALL register an, seg and dp; the pins reflect the sc/di state of the previous cycle (1-cycle latency).
REQ-028 SHALL ensure exactly zero or one anode is low in any cycle.
REQ-029 SHALL apply a dim change at the next clock, with no wait for a slot boundary.
REQ-030 SHALL apply a colon_en or blank_lz change at the next clock, with no snapshot.

Reset
REQ-031 SHALL, while rst is high at a rising edge, set sc, di, the blink counter, blink phase and the shadow registers to 0.
REQ-032 SHALL, while rst is high at a rising edge, set an=4'b1111, seg=7'h7F and dp=1.
REQ-033 SHALL honour an assertion of rst mid-slot or mid-frame: outputs are blanked at the next edge, and scanning restarts at di=0, sc=0 with a fresh snapshot after release.

Verification
REQ-034 SHALL cover basic scan: with SCAN_DIV=8, dim=3 and inputs 1,2,3,4 (hour1..min0), an cycles 1110, 1101, 1011, 0111, each for 8 clocks; seg shows 4,3,2,1.
REQ-035 SHALL cover snapshot: changing min0 from 4 to 7 while di==1 -> display still shows 4 until the next di=0 slot, then shows 7.
REQ-036 SHALL cover dash and leading-zero blanking: hour1=0, blank_lz=1, min1=6, hour0=12 -> the di=3 slot is fully blank and the di=1 and di=2 slots show seg=7'b0111111.
REQ-037 SHALL cover dimming: with SCAN_DIV=8 and dim=0, the anode is low for 2 of every 8 clocks; with dim=1 it is low for 4 of every 8 clocks.
REQ-038 SHALL cover the colon: with BLINK_DIV=20 and colon_en=1, dp is low only in di=2 slots and toggles its enable every 20 clocks; with colon_en=0, dp stays high.
REQ-039 SHALL cover mid-operation reset: rst asserted for 1 cycle while di==2 -> the next edge gives an=1111, seg=7F, dp=1, and the first active anode after release is an=1110.
